// File: rtl/lvl_states_ldst_pkg.sv
// Shared definitions for the level-state load/store engine: default widths,
// level-state word field positions and the controller state encoding.
package lvl_states_ldst_pkg;

  // Default geometry of the engine and of the level-state RAM
  localparam int DEF_NUM_LVLS         = 8;
  localparam int DEF_WIDTH_LVL_STATES = 11;
  localparam int DEF_WIDTH_BIN_ID     = 10;
  localparam int DEF_WIDTH_ADDR       = 16;

  // Level-state word layout: {dcd_bin, has_bkt}
  localparam int HAS_BKT_BIT = 0;
  localparam int DCD_BIN_LSB = 1;

  // Controller states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_LOAD_LAST = 3'd2;
  localparam logic [2:0] ST_STORE     = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/lvl_states_ldst_slot_mux.sv
// NUM_LVLS:1 word selector that picks one level-state slot out of the
// engine's flattened state bus (used to source RAM store data).
module lvl_slot_mux
  import lvl_states_ldst_pkg::*;
#(
  parameter int NUM_LVLS         = DEF_NUM_LVLS,
  parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES,
  parameter int SEL_W            = 3
) (
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] slots,
  input  logic [SEL_W-1:0]                     sel,
  output logic [WIDTH_LVL_STATES-1:0]          word
);

  // AND-OR selection: exactly one slot matches sel, others contribute zero
  always_comb begin
    word = {WIDTH_LVL_STATES{1'b0}};
    for (int i = 0; i < NUM_LVLS; i++) begin
      word = word | ({WIDTH_LVL_STATES{sel == SEL_W'(i)}} &
                     slots[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES]);
    end
  end

endmodule

// File: rtl/lvl_states_ldst.sv
// Level-state load/store controller: moves up to NUM_LVLS level-state words
// between a 1-cycle-latency RAM and the engine's per-slot state registers.
module lvl_states_ldst
  import lvl_states_ldst_pkg::*;
#(
  parameter int NUM_LVLS         = DEF_NUM_LVLS,
  parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES,
  parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
  parameter int WIDTH_ADDR       = DEF_WIDTH_ADDR
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_load_i,
  input  logic                                 start_store_i,
  input  logic [WIDTH_ADDR-1:0]                base_addr_i,
  input  logic [3:0]                           num_lvls_i,
  output logic                                 ready_o,
  output logic                                 done_o,
  output logic                                 ram_rd_o,
  output logic                                 ram_we_o,
  output logic [WIDTH_ADDR-1:0]                ram_addr_o,
  output logic [WIDTH_LVL_STATES-1:0]          ram_wdata_o,
  input  logic [WIDTH_LVL_STATES-1:0]          ram_rdata_i,
  output logic [NUM_LVLS-1:0]                  wr_states_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i
);

  localparam int IDX_W = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;
  localparam int CNT_W = $clog2(NUM_LVLS + 1);
  localparam int BUS_W = WIDTH_LVL_STATES * NUM_LVLS;

  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0]      IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH_ADDR-1:0] ADDR_ONE = WIDTH_ADDR'(1'b1);
  localparam logic [NUM_LVLS-1:0]   SLOT_ONE = NUM_LVLS'(1'b1);

  // Registered state and latched command
  logic [2:0]                  state_r;
  logic [IDX_W-1:0]            idx_r;
  logic [CNT_W-1:0]            cnt_r;
  logic [WIDTH_ADDR-1:0]       base_r;
  logic                        ready_r;
  logic                        done_r;
  logic                        rd_r;
  logic                        we_r;
  logic [WIDTH_ADDR-1:0]       addr_r;
  logic [WIDTH_LVL_STATES-1:0] wdata_r;
  logic [NUM_LVLS-1:0]         wr_r;

  // Next-state values
  logic [2:0]                  state_s;
  logic [IDX_W-1:0]            idx_s;
  logic [CNT_W-1:0]            cnt_s;
  logic [WIDTH_ADDR-1:0]       base_s;
  logic                        done_s;
  logic                        rd_s;
  logic                        we_s;
  logic [WIDTH_ADDR-1:0]       addr_s;
  logic [WIDTH_LVL_STATES-1:0] wdata_s;
  logic [NUM_LVLS-1:0]         wr_s;

  // Helpers
  logic [CNT_W-1:0]            nclip_s;
  logic                        last_s;
  logic [WIDTH_ADDR-1:0]       next_addr_s;
  logic [NUM_LVLS-1:0]         slot_onehot_s;
  logic [IDX_W-1:0]            sel_s;
  logic [WIDTH_LVL_STATES-1:0] mux_word_s;
  logic [WIDTH_LVL_STATES-1:0] load_word_s;

  // Clamp the requested level count to the number of engine slots
  always_comb begin
    if (32'(num_lvls_i) > NUM_LVLS) begin
      nclip_s = CNT_W'(NUM_LVLS);
    end else begin
      nclip_s = CNT_W'(num_lvls_i);
    end
  end

  assign last_s        = ((32'(idx_r) + 32'd1) == 32'(cnt_r));
  assign next_addr_s   = base_r + WIDTH_ADDR'(idx_r) + ADDR_ONE;
  assign slot_onehot_s = SLOT_ONE << idx_r;

  // Store data for the next cycle: slot 0 when starting, else the next slot
  always_comb begin
    if (state_r == ST_STORE) begin
      sel_s = idx_r + IDX_ONE;
    end else begin
      sel_s = IDX_ZERO;
    end
  end

  lvl_slot_mux #(
    .NUM_LVLS         (NUM_LVLS),
    .WIDTH_LVL_STATES (WIDTH_LVL_STATES),
    .SEL_W            (IDX_W)
  ) u_slot_mux (
    .slots (lvl_states_i),
    .sel   (sel_s),
    .word  (mux_word_s)
  );

  // Forward only the defined fields of a returned word; pad bits read as zero
  assign load_word_s = WIDTH_LVL_STATES'({ram_rdata_i[WIDTH_BIN_ID:DCD_BIN_LSB],
                                          ram_rdata_i[HAS_BKT_BIT]});

  // Engine data is only driven while a slot strobe is active, so an aborted
  // read return never reaches the engine
  assign lvl_states_o = (|wr_r) ? {NUM_LVLS{load_word_s}} : {BUS_W{1'b0}};

  // Controller next-state and next-output decode
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    base_s  = base_r;
    done_s  = 1'b0;
    rd_s    = 1'b0;
    we_s    = 1'b0;
    addr_s  = {WIDTH_ADDR{1'b0}};
    wdata_s = {WIDTH_LVL_STATES{1'b0}};
    wr_s    = {NUM_LVLS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (start_load_i || start_store_i) begin
          base_s = base_addr_i;
          cnt_s  = nclip_s;
          idx_s  = IDX_ZERO;
          if (nclip_s == CNT_ZERO) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else if (start_load_i) begin
            // load wins when both commands arrive together
            state_s = ST_LOAD;
            rd_s    = 1'b1;
            addr_s  = base_addr_i;
          end else begin
            state_s = ST_STORE;
            we_s    = 1'b1;
            addr_s  = base_addr_i;
            wdata_s = mux_word_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // the read issued this cycle lands next cycle into slot idx_r
        wr_s = slot_onehot_s;
        if (last_s) begin
          state_s = ST_LOAD_LAST;
        end else begin
          idx_s  = idx_r + IDX_ONE;
          rd_s   = 1'b1;
          addr_s = next_addr_s;
        end
      end
      ST_LOAD_LAST: begin
        state_s = ST_DONE;
        done_s  = 1'b1;
      end
      ST_STORE: begin
        if (last_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          idx_s   = idx_r + IDX_ONE;
          we_s    = 1'b1;
          addr_s  = next_addr_s;
          wdata_s = mux_word_s;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, command and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
      base_r  <= {WIDTH_ADDR{1'b0}};
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      rd_r    <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {WIDTH_ADDR{1'b0}};
      wdata_r <= {WIDTH_LVL_STATES{1'b0}};
      wr_r    <= {NUM_LVLS{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      base_r  <= base_s;
      ready_r <= (state_s == ST_IDLE);
      done_r  <= done_s;
      rd_r    <= rd_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      wr_r    <= wr_s;
    end
  end

  assign ready_o     = ready_r;
  assign done_o      = done_r;
  assign ram_rd_o    = rd_r;
  assign ram_we_o    = we_r;
  assign ram_addr_o  = addr_r;
  assign ram_wdata_o = wdata_r;
  assign wr_states_o = wr_r;

endmodule

// File: tb/tb_lvl_states_ldst.sv
// Self-checking bench for lvl_states_ldst: a per-cycle expectation timeline
// built from command-level rules, checked every cycle, plus literal spot checks.
module tb_lvl_states_ldst;

  localparam int NL   = 8;
  localparam int W    = 11;
  localparam int AW   = 16;
  localparam int MAXC = 512;

  logic            clk;
  logic            rst;
  logic            start_load_i;
  logic            start_store_i;
  logic [AW-1:0]   base_addr_i;
  logic [3:0]      num_lvls_i;
  logic            ready_o;
  logic            done_o;
  logic            ram_rd_o;
  logic            ram_we_o;
  logic [AW-1:0]   ram_addr_o;
  logic [W-1:0]    ram_wdata_o;
  logic [W-1:0]    ram_rdata_i;
  logic [NL-1:0]   wr_states_o;
  logic [W*NL-1:0] lvl_states_o;
  logic [W*NL-1:0] lvl_states_i;

  lvl_states_ldst dut (
    .clk           (clk),
    .rst           (rst),
    .start_load_i  (start_load_i),
    .start_store_i (start_store_i),
    .base_addr_i   (base_addr_i),
    .num_lvls_i    (num_lvls_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .ram_rd_o      (ram_rd_o),
    .ram_we_o      (ram_we_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_rdata_i   (ram_rdata_i),
    .wr_states_o   (wr_states_o),
    .lvl_states_o  (lvl_states_o),
    .lvl_states_i  (lvl_states_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-only RAM image with one cycle of read latency
  logic [W-1:0] ram_init [0:65535];
  always @(posedge clk) begin
    if (ram_rd_o) ram_rdata_i <= ram_init[ram_addr_o];
  end

  // Expected per-cycle timeline
  bit            exp_rd    [MAXC];
  bit            exp_we    [MAXC];
  bit            exp_done  [MAXC];
  bit            exp_ready [MAXC];
  bit            exp_zero  [MAXC];
  logic [AW-1:0] exp_addr  [MAXC];
  logic [W-1:0]  exp_wdata [MAXC];
  logic [NL-1:0] exp_wr    [MAXC];
  logic [W*NL-1:0] exp_lvl [MAXC];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int t);
    for (int c = t; c < t + 16 && c < MAXC; c++) begin
      exp_rd[c] = 1'b0; exp_we[c] = 1'b0; exp_done[c] = 1'b0;
      exp_ready[c] = 1'b1; exp_zero[c] = 1'b0; exp_wr[c] = '0;
    end
  endtask

  // Command-level model: a command seen in an idle cycle t is accepted and
  // its whole access pattern is laid out on the timeline.
  task automatic model_cycle(input int t, input logic ld, input logic st,
                             input logic rs, input logic [AW-1:0] b, input logic [3:0] nl);
    int n;
    logic [AW-1:0] a;
    if (rs) begin
      clear_from(t + 1);
      exp_zero[t + 1] = 1'b1;
    end else if (exp_ready[t] && (ld || st)) begin
      n = (nl > 4'd8) ? 8 : int'(nl);
      if (n == 0) begin
        exp_done[t + 1]  = 1'b1;
        exp_ready[t + 1] = 1'b0;
      end else if (ld) begin
        for (int i = 0; i < n; i++) begin
          a = b + AW'(i);
          exp_rd[t + 1 + i]   = 1'b1;
          exp_addr[t + 1 + i] = a;
          exp_wr[t + 2 + i]   = NL'(1) << i;
          exp_lvl[t + 2 + i]  = {NL{ram_init[a]}};
        end
        for (int c = t + 1; c <= t + n + 2; c++) exp_ready[c] = 1'b0;
        exp_done[t + n + 2] = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) begin
          exp_we[t + 1 + i]    = 1'b1;
          exp_addr[t + 1 + i]  = b + AW'(i);
          exp_wdata[t + 1 + i] = lvl_states_i[i*W +: W];
        end
        for (int c = t + 1; c <= t + n + 1; c++) exp_ready[c] = 1'b0;
        exp_done[t + n + 1] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, update the model, advance to the next negedge
  task automatic step(input logic ld, input logic st, input logic rs,
                      input logic [AW-1:0] b, input logic [3:0] nl);
    start_load_i  = ld;
    start_store_i = st;
    rst           = rs;
    base_addr_i   = b;
    num_lvls_i    = nl;
    model_cycle(cyc, ld, st, rs, b, nl);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);
  endtask

  // Per-cycle comparison against the timeline
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", ready_o, exp_ready[cyc]);
      chk("done", done_o, exp_done[cyc]);
      chk("ram_rd", ram_rd_o, exp_rd[cyc]);
      chk("ram_we", ram_we_o, exp_we[cyc]);
      chk("wr_states", wr_states_o, exp_wr[cyc]);
      if (exp_rd[cyc] || exp_we[cyc]) chk("ram_addr", ram_addr_o, exp_addr[cyc]);
      if (exp_we[cyc]) chk("ram_wdata", ram_wdata_o, exp_wdata[cyc]);
      if (exp_wr[cyc] != '0) chk("lvl_states", lvl_states_o, exp_lvl[cyc]);
      if (exp_zero[cyc]) begin
        chk("rst_addr", ram_addr_o, 16'h0000);
        chk("rst_wdata", ram_wdata_o, 11'h000);
        chk("rst_lvl", lvl_states_o, 88'h0);
      end
    end
  end

  initial begin : driver
    int n_rd, n_we, n_dn, n_wr, first_we;
    for (int a = 0; a < 65536; a++) ram_init[a] = 11'h000;
    ram_init[16'h0010] = 11'h005;
    ram_init[16'h0011] = 11'h7FF;
    ram_init[16'h0012] = 11'h402;
    ram_init[16'h0020] = 11'h123;
    ram_init[16'h0021] = 11'h456;
    for (int i = 0; i < 12; i++) ram_init[16'h0100 + i] = 11'h200 + 11'(i * 17);
    for (int i = 0; i < 5; i++)  ram_init[16'h0200 + i] = 11'h0A0 + 11'(i);
    for (int i = 0; i < NL; i++) lvl_states_i[i*W +: W] = 11'(i + 1);
    for (int c = 0; c < MAXC; c++) begin
      exp_ready[c] = 1'b1; exp_rd[c] = 1'b0; exp_we[c] = 1'b0; exp_done[c] = 1'b0;
      exp_zero[c] = 1'b0; exp_wr[c] = '0; exp_addr[c] = '0; exp_wdata[c] = '0; exp_lvl[c] = '0;
    end
    rst = 1'b1; start_load_i = 1'b0; start_store_i = 1'b0;
    base_addr_i = 16'h0000; num_lvls_i = 4'd0;
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 1'b1, 16'h0000, 4'd0);
    chk_on = 1'b1;
    chk("reset_ready", ready_o, 1'b1);
    chk("reset_wr", wr_states_o, 8'h00);
    idle();

    // Load N=3 from 0x0010
    step(1'b1, 1'b0, 1'b0, 16'h0010, 4'd3);
    chk("ld_rd0", ram_rd_o, 1'b1);
    chk("ld_addr0", ram_addr_o, 16'h0010);
    idle();
    chk("ld_wr0", wr_states_o, 8'h01);
    chk("ld_dat0", lvl_states_o[10:0], 11'h005);
    idle();
    chk("ld_wr1", wr_states_o, 8'h02);
    chk("ld_dat1", lvl_states_o[87:77], 11'h7FF);
    idle();
    chk("ld_wr2", wr_states_o, 8'h04);
    chk("ld_dat2", lvl_states_o[32:22], 11'h402);
    idle();
    chk("ld_done", done_o, 1'b1);
    idle();
    chk("ld_ready", ready_o, 1'b1);

    // Store N=8 to 0xFFFE, wrapping
    step(1'b0, 1'b1, 1'b0, 16'hFFFE, 4'd8);
    chk("st_we0", ram_we_o, 1'b1);
    chk("st_addr0", ram_addr_o, 16'hFFFE);
    chk("st_dat0", ram_wdata_o, 11'h001);
    idle();
    chk("st_addr1", ram_addr_o, 16'hFFFF);
    idle();
    chk("st_addr2", ram_addr_o, 16'h0000);
    chk("st_dat2", ram_wdata_o, 11'h003);
    repeat (5) idle();
    chk("st_addr7", ram_addr_o, 16'h0005);
    chk("st_dat7", ram_wdata_o, 11'h008);
    idle();
    chk("st_done", done_o, 1'b1);
    idle();

    // Both commands together: load only
    step(1'b1, 1'b1, 1'b0, 16'h0020, 4'd2);
    n_rd = 0; n_we = 0; n_dn = 0;
    for (int k = 0; k < 8; k++) begin
      n_rd += int'(ram_rd_o); n_we += int'(ram_we_o); n_dn += int'(done_o);
      idle();
    end
    chk("both_rd", n_rd, 2);
    chk("both_we", n_we, 0);
    chk("both_done", n_dn, 1);

    // Zero-length load and store
    step(1'b1, 1'b0, 1'b0, 16'h0030, 4'd0);
    chk("n0_done", done_o, 1'b1);
    chk("n0_rd", ram_rd_o, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b0, 16'h0030, 4'd0);
    chk("n0s_done", done_o, 1'b1);
    chk("n0s_we", ram_we_o, 1'b0);
    idle();

    // Over-length load clamps to 8
    step(1'b1, 1'b0, 1'b0, 16'h0100, 4'd12);
    n_rd = 0; n_wr = 0; n_dn = 0;
    for (int k = 0; k < 14; k++) begin
      n_rd += int'(ram_rd_o); n_wr += int'(wr_states_o != 8'h00); n_dn += int'(done_o);
      idle();
    end
    chk("clamp_rd", n_rd, 8);
    chk("clamp_wr", n_wr, 8);
    chk("clamp_done", n_dn, 1);

    // Reset during an N=5 load
    step(1'b1, 1'b0, 1'b0, 16'h0200, 4'd5);
    idle();
    step(1'b0, 1'b0, 1'b1, 16'h0000, 4'd0);
    chk("abort_ready", ready_o, 1'b1);
    chk("abort_wr", wr_states_o, 8'h00);
    n_rd = 0; n_wr = 0; n_dn = 0;
    for (int k = 0; k < 8; k++) begin
      n_rd += int'(ram_rd_o); n_wr += int'(wr_states_o != 8'h00); n_dn += int'(done_o);
      idle();
    end
    chk("abort_rd", n_rd, 0);
    chk("abort_wrs", n_wr, 0);
    chk("abort_done", n_dn, 0);

    // Store held high across an active load
    step(1'b1, 1'b0, 1'b0, 16'h0010, 4'd3);
    first_we = -1;
    for (int k = 0; k < 8; k++) begin
      if (ram_we_o && first_we < 0) first_we = k + 1;
      step(1'b0, 1'b1, 1'b0, 16'h0040, 4'd2);
    end
    chk("held_store_start", first_we, 7);
    repeat (6) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
